ram_req_ctrl: RTL
=================

Name: ram_req_ctrl

Overview:
- Request/response front end directly upstream of the single-port block RAM (1-cycle read latency, always-reading).
- Converts a valid/ready request stream (read or write) into RAM address/write_en/write_data, captures read_data one cycle later, and presents it on a backpressured valid/ready response stream.
- Guarantees no read result is lost when the consumer stalls.

Parameters:
- SIZE, 8, word width in bits; must match the RAM SIZE.
- DEPTH, 256, number of RAM entries; must match the RAM DEPTH; AW = $clog2(DEPTH).

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- req_valid  in  1  request present
- req_ready  out  1  request accepted when valid&&ready
- req_write  in  1  1 = write, 0 = read
- req_address  in  AW  target address
- req_wdata  in  SIZE  write data
- rsp_valid  out  1  read data available
- rsp_ready  in  1  consumer takes data when valid&&ready
- rsp_data  out  SIZE  read result
- rsp_err  out  1  out-of-range read flag (see Optional Feature)
- ram_address  out  AW  to RAM address
- ram_write_data  out  SIZE  to RAM write_data
- ram_write_en  out  1  to RAM write_en
- ram_read_data  in  SIZE  from RAM read_data (value of the previous cycle's address)

Behaviour:
- Reset (rst_n low, asynchronous): response buffer emptied, inflight=0, rsp_valid=0, rsp_data=0, rsp_err=0. req_ready=0 and ram_write_en=0 while rst_n is low.
- Any read in flight when reset asserts is discarded. Reset mid-stream never produces a response after release.
- accept = req_valid && req_ready.
- RAM drive is combinational, in the same cycle as accept:
  - ram_address = req_address
  - ram_write_data = req_wdata
  - ram_write_en = accept && req_write
- Read accept sets inflight=1 for the next cycle. Otherwise inflight=0 next cycle.
- When inflight=1, ram_read_data is pushed into the response buffer that cycle.
- Response buffer: 2-entry FIFO, occ in 0..2.
  - rsp_valid = (occ != 0).
  - rsp_data = head entry.
  - Pop on rsp_valid && rsp_ready.
- req_ready = rst_n && (occ + inflight - pop) < 2.
  - This combinational path from rsp_ready to req_ready is intentional.
  - Gives one read per cycle sustained when rsp_ready is held 1.
- Writes use the same req_ready condition: a single ready signal, no write-only bypass. Writes produce no response.
- Latency: read accepted in cycle N → rsp_valid earliest in cycle N+2 (RAM register at N+1 edge, buffer push at N+1, visible at N+2).
- Ordering:
  - Responses return strictly in request order.
  - Read after write to the same address, in consecutive accepts, returns the new value (the RAM write completes at the write cycle's edge).
- Simultaneous push and pop: occ unchanged, FIFO order preserved, including the occ=1 case where the head is popped and the new entry becomes head.
- Full (occ=2): req_ready=0 unless pop occurs that cycle. Overflow is impossible by construction; assertion required.
- Empty: rsp_valid=0; rsp_data holds its last value (don't-care for verification).
- Idle cycles: ram_write_en=0; the RAM read of the arbitrary req_address is ignored because inflight=0.

Optional Feature:
- Macro RAM_REQ_CTRL_RANGE_CHECK_EN (meaningful when DEPTH is not a power of two).
- Defined:
  - A request with req_address >= DEPTH is still accepted under normal ready rules.
  - Such a write: ram_write_en forced 0, write dropped.
  - Such a read: response pushed with data 0 and rsp_err=1, in the same slot and order as a normal read.
  - rsp_err travels with each buffer entry.
- Undefined:
  - No check; address is passed through unchanged.
  - rsp_err tied 0; buffer stores data only.

Decomposition:
- Package ram_req_pkg:
  - localparam RSP_DEPTH = 2
  - typedef occ_t (2-bit occupancy)
  - typedef rsp_entry_t {data, err}
- Sub-module ram_rsp_buffer: 2-entry FIFO with push/pop/occ, async active-low reset.
- Top: inflight flag, ready logic, RAM drive.

Test Plan:
- Reset then write 0xA5 @3, read @3 with rsp_ready=1 → rsp_data=0xA5 exactly 2 cycles after the read accept; ram_write_en high only in the write cycle.
- Back-to-back reads @0..7 (pre-written 0x10+i), rsp_ready=1 → req_ready stays 1; 8 responses 0x10..0x17 on consecutive cycles in order.
- rsp_ready=0, issue 4 reads → req_ready drops after 2 accepts; occ=2; no overflow. Then rsp_ready=1 → remaining reads accepted; all 4 values return in order.
- Write 0x3C @5 immediately followed by read @5 → response 0x3C, not the old value.
- rst_n pulsed low one cycle after a read accept → rsp_valid stays 0 after release; next read returns correct data.
- With RAM_REQ_CTRL_RANGE_CHECK_EN, DEPTH=200: write 0xFF @210 then read @210 → ram_write_en=0; response data 0, rsp_err=1. A read @199 in the same run returns rsp_err=0.

Source files
------------

// File: rtl/ram_req_pkg.sv
// Shared types and helpers for the RAM request/response front end.
package ram_req_pkg;

    localparam int unsigned RSP_DEPTH = 2;

    // Occupancy of the response buffer, 0..RSP_DEPTH.
    typedef logic [1:0] occ_t;

    localparam occ_t OCC_EMPTY = 2'd0;
    localparam occ_t OCC_ONE   = 2'd1;
    localparam occ_t OCC_FULL  = 2'd2;

    // True when a new read can be accepted without risking a buffer overflow:
    // the entries already stored plus the read still in flight, minus the
    // entry leaving this cycle, must leave at least one free slot.
    function automatic logic has_room(input occ_t occ, input logic inflight, input logic pop);
        logic [2:0] pending;
        pending = {1'b0, occ} + {2'b00, inflight} - {2'b00, pop};
        return (pending < 3'(RSP_DEPTH));
    endfunction

endpackage

// File: rtl/ram_rsp_buffer.sv
// Two-entry response FIFO. Entry 0 is always the head, so the head output is
// a plain register and a push/pop at occupancy 1 lands the new entry as head.
module ram_rsp_buffer
    import ram_req_pkg::*;
#(
    parameter int unsigned W = 8
) (
    input  logic         clk_i,
    input  logic         rst_ni,
    input  logic         push_i,
    input  logic [W-1:0] push_data_i,
    input  logic         pop_i,
    output occ_t         occ_o,
    output logic [W-1:0] head_o
);

    occ_t         occ_q, occ_d;
    logic [W-1:0] e0_q, e0_d;
    logic [W-1:0] e1_q, e1_d;

    // Next-state of the shift-style storage for every push/pop combination.
    always_comb begin
        occ_d = occ_q;
        e0_d  = e0_q;
        e1_d  = e1_q;
        case ({push_i, pop_i})
            2'b10: begin
                if (occ_q == OCC_EMPTY) begin
                    e0_d  = push_data_i;
                    occ_d = OCC_ONE;
                end else if (occ_q == OCC_ONE) begin
                    e1_d  = push_data_i;
                    occ_d = OCC_FULL;
                end else begin
                    occ_d = occ_q;
                end
            end
            2'b01: begin
                if (occ_q == OCC_FULL) begin
                    e0_d  = e1_q;
                    occ_d = OCC_ONE;
                end else if (occ_q == OCC_ONE) begin
                    occ_d = OCC_EMPTY;
                end else begin
                    occ_d = occ_q;
                end
            end
            2'b11: begin
                if (occ_q == OCC_FULL) begin
                    e0_d = e1_q;
                    e1_d = push_data_i;
                end else if (occ_q == OCC_ONE) begin
                    e0_d = push_data_i;
                end else begin
                    e0_d  = push_data_i;
                    occ_d = OCC_ONE;
                end
            end
            default: begin
                occ_d = occ_q;
            end
        endcase
    end

    // Storage and occupancy registers; reset empties the buffer and clears data.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            occ_q <= OCC_EMPTY;
            e0_q  <= '0;
            e1_q  <= '0;
        end else begin
            occ_q <= occ_d;
            e0_q  <= e0_d;
            e1_q  <= e1_d;
        end
    end

    assign occ_o  = occ_q;
    assign head_o = e0_q;

    ram_rsp_buffer_chk u_chk (
        .clk_i  (clk_i),
        .rst_ni (rst_ni),
        .push_i (push_i),
        .pop_i  (pop_i),
        .occ_i  (occ_q)
    );

endmodule

// File: rtl/ram_rsp_buffer_chk.sv
// Protocol checks for the two-entry response buffer.
module ram_rsp_buffer_chk
    import ram_req_pkg::*;
(
    input logic clk_i,
    input logic rst_ni,
    input logic push_i,
    input logic pop_i,
    input occ_t occ_i
);

    // A push into a full buffer without a simultaneous pop would lose data.
    a_no_overflow: assert property (@(posedge clk_i) disable iff (!rst_ni)
        !(push_i && !pop_i && (occ_i == OCC_FULL)))
        else $error("ram_rsp_buffer overflow");

    // A pop is only legal when the buffer holds an entry.
    a_no_underflow: assert property (@(posedge clk_i) disable iff (!rst_ni)
        !(pop_i && (occ_i == OCC_EMPTY)))
        else $error("ram_rsp_buffer underflow");

    // Occupancy never exceeds the buffer depth.
    a_occ_range: assert property (@(posedge clk_i) disable iff (!rst_ni)
        (occ_i <= OCC_FULL))
        else $error("ram_rsp_buffer occupancy out of range");

endmodule

// File: rtl/ram_req_ctrl.sv
// Request/response front end for a single-port block RAM with one cycle of
// read latency. Requests drive the RAM combinationally; read data returning
// one cycle later is captured into a two-entry buffer so a stalled consumer
// never loses a result.
// Optional feature: RAM_REQ_CTRL_RANGE_CHECK_EN drops writes to addresses
// >= DEPTH and answers such reads with data 0 and rsp_err_o=1.
module ram_req_ctrl
    import ram_req_pkg::*;
#(
    parameter  int unsigned SIZE  = 8,
    parameter  int unsigned DEPTH = 256,
    localparam int unsigned AW    = $clog2(DEPTH)
) (
    input  logic            clk_i,
    input  logic            rst_ni,
    input  logic            req_valid_i,
    output logic            req_ready_o,
    input  logic            req_write_i,
    input  logic [AW-1:0]   req_address_i,
    input  logic [SIZE-1:0] req_wdata_i,
    output logic            rsp_valid_o,
    input  logic            rsp_ready_i,
    output logic [SIZE-1:0] rsp_data_o,
    output logic            rsp_err_o,
    output logic [AW-1:0]   ram_address_o,
    output logic [SIZE-1:0] ram_write_data_o,
    output logic            ram_write_en_o,
    input  logic [SIZE-1:0] ram_read_data_i
);

`ifdef RAM_REQ_CTRL_RANGE_CHECK_EN
    typedef struct packed {
        logic [SIZE-1:0] data;
        logic            err;
    } rsp_entry_t;

    localparam logic [AW:0] DEPTH_L = DEPTH[AW:0];

    logic in_range_s;
    logic oor_q, oor_d;
`else
    typedef struct packed {
        logic [SIZE-1:0] data;
    } rsp_entry_t;
`endif

    localparam int unsigned EW = $bits(rsp_entry_t);

    logic       inflight_q, inflight_d;
    logic       accept_s;
    logic       pop_s;
    occ_t       occ_s;
    rsp_entry_t push_entry_s;
    rsp_entry_t head_entry_s;

    // Handshake, RAM drive and response-buffer push data for this cycle.
    always_comb begin
        rsp_valid_o      = (occ_s != OCC_EMPTY);
        pop_s            = rsp_valid_o && rsp_ready_i;
        req_ready_o      = rst_ni && has_room(occ_s, inflight_q, pop_s);
        accept_s         = req_valid_i && req_ready_o;
        ram_address_o    = req_address_i;
        ram_write_data_o = req_wdata_i;
        inflight_d       = accept_s && !req_write_i;
        push_entry_s     = '0;
`ifdef RAM_REQ_CTRL_RANGE_CHECK_EN
        in_range_s        = ({1'b0, req_address_i} < DEPTH_L);
        ram_write_en_o    = accept_s && req_write_i && in_range_s;
        oor_d             = inflight_d && !in_range_s;
        push_entry_s.data = oor_q ? '0 : ram_read_data_i;
        push_entry_s.err  = oor_q;
        rsp_data_o        = head_entry_s.data;
        rsp_err_o         = head_entry_s.err;
`else
        ram_write_en_o    = accept_s && req_write_i;
        push_entry_s.data = ram_read_data_i;
        rsp_data_o        = head_entry_s.data;
        rsp_err_o         = 1'b0;
`endif
    end

    // Tracks the read whose RAM data arrives next cycle; reset discards it.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            inflight_q <= 1'b0;
`ifdef RAM_REQ_CTRL_RANGE_CHECK_EN
            oor_q      <= 1'b0;
`endif
        end else begin
            inflight_q <= inflight_d;
`ifdef RAM_REQ_CTRL_RANGE_CHECK_EN
            oor_q      <= oor_d;
`endif
        end
    end

    ram_rsp_buffer #(
        .W (EW)
    ) u_rsp_buffer (
        .clk_i       (clk_i),
        .rst_ni      (rst_ni),
        .push_i      (inflight_q),
        .push_data_i (push_entry_s),
        .pop_i       (pop_s),
        .occ_o       (occ_s),
        .head_o      (head_entry_s)
    );

endmodule
